parallel_input: RTL and testbench
=================================

# parallel_input

Memory-mapped 32-bit parallel input port; the read-side counterpart of the SoC's parallel output peripheral. It attaches to one device slot of a bus hub. It synchronizes external `io` pins into the core clock domain and exposes the live pin value. It also latches sticky rising/falling-edge flags (write-1-to-clear) and drives a maskable level interrupt.

## Interface
Parameters:
- `BASEADDR`, `32'h80000000`: base of the 16-byte register window (4 words).
- `SYNC_STAGES`, `2`: flip-flop synchronizer depth on `io`, legal range 2..4.

Ports:
- `clk`  input  1  core clock; single clock domain.
- `rst`  input  1  asynchronous, active-high reset.
- `addr`  input  32  byte address from the hub.
- `wdata`  input  32  write data.
- `wmask`  input  4  byte-lane write enables; bit n enables `wdata[8n+7:8n]`.
- `ren`  input  1  read strobe, one cycle per transaction.
- `wen`  input  1  write strobe, one cycle per transaction.
- `rdata`  output  32  read data, valid while `ready`=1.
- `ready`  output  1  one-cycle completion pulse.
- `active`  output  1  combinational address decode.
- `io`  input  32  asynchronous external pins.
- `irq`  output  1  level interrupt.

## Operation
- Address decode:
  - `active` = (`addr` >= `BASEADDR`) && (`addr` < `BASEADDR`+16).
  - Register select is `addr[3:2]`; `addr[1:0]` is ignored.
- Registers:
  - 0x0 DATA (RO): synchronized `io`. Writes are ignored but still complete.
  - 0x4 RISE (W1C): bit set on a 0→1 transition of the synchronized pin.
  - 0x8 FALL (W1C): bit set on a 1→0 transition of the synchronized pin.
  - 0xC MASK (RW): per-bit interrupt enable.
- Synchronizer: `SYNC_STAGES` flip-flops per bit, then a `prev` register holding the previous synchronized value.
  - rise = sync & ~prev.
  - fall = ~sync & prev.
- Priming:
  - After reset, a counter suppresses edge capture for `SYNC_STAGES`+1 cycles.
  - Pins that are already high at reset therefore do not set RISE.
  - `prev` tracks `sync` normally during priming.
- W1C update: for each bit, new = (old & ~(clear_bit)) | edge_bit.
  - clear_bit = `wdata` bit, gated by its `wmask` lane, and only on a write to that register.
  - A simultaneous edge and clear leaves the bit set (edge wins).
- MASK write: each byte lane enabled in `wmask` is replaced; other lanes are kept.
- `irq` = |((RISE | FALL) & MASK), registered.
- Transactions:
  - A strobe (`ren` or `wen`) is accepted only when `active`=1; otherwise it is ignored and produces no `ready`.
  - Strobes at most one cycle apart are each accepted and each produce their own `ready`.
- `ren` and `wen` in the same cycle:
  - The write is performed.
  - `rdata` returns the pre-write value.
  - A single `ready` pulse is issued.
- `rdata`:
  - Driven with the selected register on a read.
  - 0 on write-only completions.
  - 0 whenever `ready`=0.

## Timing
- Reset values: `rdata`=0, `ready`=0, `irq`=0; sync/prev=0, RISE=FALL=MASK=0; priming counter loaded.
- Reset asserted mid-transaction: the pending `ready` is dropped and all state returns to reset values immediately (asynchronous).
- Transaction latency:
  - Strobe accepted at cycle t → `ready`=1 and `rdata` valid at t+1, for exactly one cycle.
  - Register update from a write is visible to a read strobed at t+1.
- `io` path latency:
  - An `io` change settled before edge k is visible in DATA `SYNC_STAGES` cycles later.
  - RISE/FALL are set one cycle after the DATA change.
  - `irq` rises one cycle after the flag is set.
- `active` is purely combinational from `addr`, with zero latency.

## Test plan
- Reset with `io`=32'hFFFF_FFFF, held 10 cycles: DATA reads 32'hFFFF_FFFF; RISE reads 0; FALL reads 0; `irq`=0.
- `io[3]` toggles 0→1 at cycle 0 (`SYNC_STAGES`=2): DATA bit 3 is set at cycle 2; RISE=32'h8 at cycle 3. Write 32'h8 to RISE → RISE reads 0.
- MASK=32'h0000_0100, then `io[8]` falls: FALL=32'h100, `irq`=1 one cycle later. W1C FALL with `wmask`=4'b0001 → bit remains set and `irq` stays 1. W1C with `wmask`=4'b0010 → cleared, `irq`=0 next cycle.
- Edge on bit 0 in the same cycle as a W1C write of 32'h1 to RISE: RISE bit 0 remains 1.
- Back-to-back reads of 0x0, 0x4, 0x8, 0xC at cycles 0-3: `ready`=1 on cycles 1-4 with matching `rdata`. A `ren` with `addr`=`BASEADDR`+16 → `active`=0 and no `ready`.
- `rst` asserted the cycle after a `ren`: `ready` stays 0, `rdata`=0, MASK=0 upon release.

Source files
------------

// File: rtl/parallel_input.sv
// parallel_input
// Memory-mapped 32-bit parallel input port occupying a 16-byte window at
// BASEADDR. External pins are synchronized into the clk domain; the live value
// is readable, and rising/falling edges latch sticky write-1-to-clear flags
// that drive a maskable, registered level interrupt.
//
// Register map (select = addr[3:2], addr[1:0] ignored):
//   0x0 DATA  RO   synchronized io (writes complete but have no effect)
//   0x4 RISE  W1C  sticky 0->1 flags
//   0x8 FALL  W1C  sticky 1->0 flags
//   0xC MASK  RW   per-bit interrupt enable, byte-lane writable
//
// Ports:
//   clk, rst         core clock, asynchronous active-high reset
//   addr, wdata      bus byte address and write data
//   wmask            byte-lane write enables
//   ren, wen         one-cycle read / write strobes
//   rdata, ready     read data and one-cycle completion pulse (1 cycle later)
//   active           combinational window decode of addr
//   io               asynchronous external pins
//   irq              level interrupt: |((RISE | FALL) & MASK)
module parallel_input #(
  parameter logic [31:0] BASEADDR    = 32'h8000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        ren,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
  input  logic [31:0] io,
  output logic        irq
);

  // Priming length covers the synchronizer plus the prev register, so pins
  // that are already high when reset releases never look like edges.
  localparam int                PRIME_W    = 3;
  localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_RISE = 2'd1,
    REG_FALL = 2'd2,
    REG_MASK = 2'd3
  } reg_sel_e;

  logic [31:0]        sync_r [SYNC_STAGES];
  logic [31:0]        prev_r;
  logic [PRIME_W-1:0] prime_cnt_r;
  logic [31:0]        rise_r;
  logic [31:0]        fall_r;
  logic [31:0]        mask_r;
  logic [31:0]        rdata_r;
  logic               ready_r;
  logic               irq_r;

  logic [31:0] sync_s;
  logic [31:0] lane_s;
  logic        acc_s;
  logic        wr_s;
  logic        rd_s;
  reg_sel_e    sel_s;
  logic [31:0] rise_edge_s;
  logic [31:0] fall_edge_s;
  logic [31:0] clr_rise_s;
  logic [31:0] clr_fall_s;
  logic [31:0] rise_next_s;
  logic [31:0] fall_next_s;
  logic [31:0] mask_next_s;
  logic [31:0] rd_val_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Window decode, lane expansion, register select and next-state logic.
  always_comb begin
    // 33-bit compare so a window touching the top of the map cannot wrap.
    active = ({1'b0, addr} >= {1'b0, BASEADDR}) &&
             ({1'b0, addr} <  ({1'b0, BASEADDR} + 33'd16));
    sel_s  = reg_sel_e'(addr[3:2]);
    acc_s  = (ren | wen) & active;
    wr_s   = wen & active;
    rd_s   = ren & active;
    lane_s = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};

    if (prime_cnt_r == {PRIME_W{1'b0}}) begin
      rise_edge_s = sync_s & ~prev_r;
      fall_edge_s = ~sync_s & prev_r;
    end else begin
      rise_edge_s = 32'd0;
      fall_edge_s = 32'd0;
    end

    if (wr_s && (sel_s == REG_RISE)) begin
      clr_rise_s = wdata & lane_s;
    end else begin
      clr_rise_s = 32'd0;
    end

    if (wr_s && (sel_s == REG_FALL)) begin
      clr_fall_s = wdata & lane_s;
    end else begin
      clr_fall_s = 32'd0;
    end

    // Edge is ORed in after the clear so a coincident edge wins.
    rise_next_s = (rise_r & ~clr_rise_s) | rise_edge_s;
    fall_next_s = (fall_r & ~clr_fall_s) | fall_edge_s;

    if (wr_s && (sel_s == REG_MASK)) begin
      mask_next_s = (mask_r & ~lane_s) | (wdata & lane_s);
    end else begin
      mask_next_s = mask_r;
    end

    case (sel_s)
      REG_DATA: rd_val_s = sync_s;
      REG_RISE: rd_val_s = rise_r;
      REG_FALL: rd_val_s = fall_r;
      REG_MASK: rd_val_s = mask_r;
      default:  rd_val_s = 32'd0;
    endcase
  end

  // Pin synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= 32'd0;
      end
    end else begin
      sync_r[0] <= io;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Previous synchronized value and post-reset edge-suppression counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_r      <= 32'd0;
      prime_cnt_r <= PRIME_LOAD;
    end else begin
      prev_r <= sync_s;
      if (prime_cnt_r != {PRIME_W{1'b0}}) begin
        prime_cnt_r <= prime_cnt_r - {{(PRIME_W-1){1'b0}}, 1'b1};
      end else begin
        prime_cnt_r <= prime_cnt_r;
      end
    end
  end

  // Edge flag, mask and interrupt registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_r <= 32'd0;
      fall_r <= 32'd0;
      mask_r <= 32'd0;
      irq_r  <= 1'b0;
    end else begin
      rise_r <= rise_next_s;
      fall_r <= fall_next_s;
      mask_r <= mask_next_s;
      irq_r  <= |((rise_r | fall_r) & mask_r);
    end
  end

  // Bus response: data sampled before any same-cycle write takes effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_r <= 1'b0;
      rdata_r <= 32'd0;
    end else begin
      ready_r <= acc_s;
      if (rd_s) begin
        rdata_r <= rd_val_s;
      end else begin
        rdata_r <= 32'd0;
      end
    end
  end

  assign rdata = rdata_r;
  assign ready = ready_r;
  assign irq   = irq_r;

endmodule

// File: tb/tb_parallel_input.sv
// tb_parallel_input
// Self-checking bench for parallel_input (default parameters, SYNC_STAGES=2).
// Expected read data is pushed to a queue as each strobe is driven and popped
// when the completion is observed one cycle later.
module tb_parallel_input;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        ren;
  logic        wen;
  logic [31:0] rdata;
  logic        ready;
  logic        active;
  logic [31:0] io;
  logic        irq;

  int          errors;
  int          checks;
  logic [31:0] exp_q[$];
  logic [31:0] want;

  parallel_input #(
    .BASEADDR    (BASE),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .wdata  (wdata),
    .wmask  (wmask),
    .ren    (ren),
    .wen    (wen),
    .rdata  (rdata),
    .ready  (ready),
    .active (active),
    .io     (io),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one strobe for a single cycle; returns 1 time unit after the
  // sampling edge, when that strobe's completion is visible.
  task automatic strobe(input logic [31:0] a, input logic r, input logic w,
                        input logic [31:0] d, input logic [3:0] m);
    addr  = a;
    ren   = r;
    wen   = w;
    wdata = d;
    wmask = m;
    @(posedge clk);
    #1;
    ren = 1'b0;
    wen = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] pins);
    io  = pins;
    ren = 1'b0;
    wen = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'hFFFF_FFFF;
    exp_tab[1] = 32'h0;
    exp_tab[2] = 32'h0;
    exp_tab[3] = 32'h0;
    io = 32'hFFFF_FFFF; rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = BASE;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || rdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rdata=%h irq=%b, expected 0/0/0", ready, rdata, irq);
    end
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_tab[i]);
      strobe(BASE + 32'(i * 4), 1'b1, 1'b0, 32'd0, 4'd0);
      want = exp_q.pop_front();
      checks++;
      if (ready !== 1'b1 || rdata !== want) begin
        errors++;
        $display("FAIL reset_read%0d: ready=%b rdata=%h, expected ready=1 rdata=%h", i, ready, rdata, want);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: irq=%b, expected 0", irq);
    end
  endtask

  task automatic test_rise();
    logic [31:0] a_tab [4];
    logic [31:0] e_tab [4];
    a_tab[0] = 32'h0; e_tab[0] = 32'h0;
    a_tab[1] = 32'h0; e_tab[1] = 32'h0;
    a_tab[2] = 32'h0; e_tab[2] = 32'h8;
    a_tab[3] = 32'h4; e_tab[3] = 32'h8;
    do_reset(32'h0);
    io = 32'h8;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(e_tab[i]);
      strobe(BASE + a_tab[i], 1'b1, 1'b0, 32'd0, 4'd0);
      want = exp_q.pop_front();
      checks++;
      if (ready !== 1'b1 || rdata !== want) begin
        errors++;
        $display("FAIL rise_seq%0d: ready=%b rdata=%h, expected ready=1 rdata=%h", i, ready, rdata, want);
      end
    end
    exp_q.push_back(32'h0);
    strobe(BASE + 32'h4, 1'b0, 1'b1, 32'h8, 4'hF);
    want = exp_q.pop_front();
    checks++;
    if (ready !== 1'b1 || rdata !== want) begin
      errors++;
      $display("FAIL rise_w1c_ack: ready=%b rdata=%h, expected ready=1 rdata=%h", ready, rdata, want);
    end
    exp_q.push_back(32'h0);
    strobe(BASE + 32'h4, 1'b1, 1'b0, 32'd0, 4'd0);
    want = exp_q.pop_front();
    checks++;
    if (ready !== 1'b1 || rdata !== want) begin
      errors++;
      $display("FAIL rise_cleared: ready=%b rdata=%h, expected ready=1 rdata=%h", ready, rdata, want);
    end
  endtask

  task automatic test_irq();
    do_reset(32'h100);
    strobe(BASE + 32'hC, 1'b0, 1'b1, 32'h0000_0100, 4'hF);
    io = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_early: irq=%b, expected 0", irq);
    end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: irq=%b, expected 1", irq);
    end
    exp_q.push_back(32'h100);
    strobe(BASE + 32'h8, 1'b1, 1'b0, 32'd0, 4'd0);
    want = exp_q.pop_front();
    checks++;
    if (ready !== 1'b1 || rdata !== want) begin
      errors++;
      $display("FAIL fall_set: ready=%b rdata=%h, expected ready=1 rdata=%h", ready, rdata, want);
    end
    strobe(BASE + 32'h8, 1'b0, 1'b1, 32'h100, 4'b0001);
    exp_q.push_back(32'h100);
    strobe(BASE + 32'h8, 1'b1, 1'b0, 32'd0, 4'd0);
    want = exp_q.pop_front();
    checks++;
    if (ready !== 1'b1 || rdata !== want || irq !== 1'b1) begin
      errors++;
      $display("FAIL fall_wrong_lane: ready=%b rdata=%h irq=%b, expected ready=1 rdata=%h irq=1", ready, rdata, irq, want);
    end
    strobe(BASE + 32'h8, 1'b0, 1'b1, 32'h100, 4'b0010);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold_one_cycle: irq=%b, expected 1", irq);
    end
    exp_q.push_back(32'h0);
    strobe(BASE + 32'h8, 1'b1, 1'b0, 32'd0, 4'd0);
    want = exp_q.pop_front();
    checks++;
    if (ready !== 1'b1 || rdata !== want || irq !== 1'b0) begin
      errors++;
      $display("FAIL fall_cleared: ready=%b rdata=%h irq=%b, expected ready=1 rdata=%h irq=0", ready, rdata, irq, want);
    end
  endtask

  task automatic test_edge_wins();
    do_reset(32'h0);
    io = 32'h1;
    exp_q.push_back(32'h0);
    strobe(BASE + 32'h4, 1'b1, 1'b0, 32'd0, 4'd0);
    want = exp_q.pop_front();
    checks++;
    if (ready !== 1'b1 || rdata !== want) begin
      errors++;
      $display("FAIL edge_pre: ready=%b rdata=%h, expected ready=1 rdata=%h", ready, rdata, want);
    end
    @(posedge clk);
    #1;
    strobe(BASE + 32'h4, 1'b0, 1'b1, 32'h1, 4'hF);
    exp_q.push_back(32'h1);
    strobe(BASE + 32'h4, 1'b1, 1'b0, 32'd0, 4'd0);
    want = exp_q.pop_front();
    checks++;
    if (ready !== 1'b1 || rdata !== want) begin
      errors++;
      $display("FAIL edge_wins: ready=%b rdata=%h, expected ready=1 rdata=%h", ready, rdata, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e_tab [4];
    e_tab[0] = 32'h0000_005A;
    e_tab[1] = 32'h0;
    e_tab[2] = 32'h0;
    e_tab[3] = 32'hA5FF_0F0F;
    do_reset(32'h5A);
    exp_q.push_back(32'h0);
    strobe(BASE + 32'hC, 1'b0, 1'b1, 32'hA5A5_0F0F, 4'hF);
    want = exp_q.pop_front();
    checks++;
    if (ready !== 1'b1 || rdata !== want) begin
      errors++;
      $display("FAIL write_ack: ready=%b rdata=%h, expected ready=1 rdata=%h", ready, rdata, want);
    end
    strobe(BASE + 32'hC, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0100);
    strobe(BASE + 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(e_tab[i]);
      strobe(BASE + 32'(i * 4), 1'b1, 1'b0, 32'd0, 4'd0);
      want = exp_q.pop_front();
      checks++;
      if (ready !== 1'b1 || rdata !== want) begin
        errors++;
        $display("FAIL b2b_read%0d: ready=%b rdata=%h, expected ready=1 rdata=%h", i, ready, rdata, want);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL b2b_idle: ready=%b rdata=%h, expected 0/0", ready, rdata);
    end
    exp_q.push_back(32'hA5FF_0F0F);
    strobe(BASE + 32'hC, 1'b1, 1'b1, 32'h1234_5678, 4'hF);
    want = exp_q.pop_front();
    checks++;
    if (ready !== 1'b1 || rdata !== want) begin
      errors++;
      $display("FAIL rw_same_cycle: ready=%b rdata=%h, expected ready=1 rdata=%h", ready, rdata, want);
    end
    exp_q.push_back(32'h1234_5678);
    strobe(BASE + 32'hE, 1'b1, 1'b0, 32'd0, 4'd0);
    want = exp_q.pop_front();
    checks++;
    if (ready !== 1'b1 || rdata !== want) begin
      errors++;
      $display("FAIL rw_followup: ready=%b rdata=%h, expected ready=1 rdata=%h", ready, rdata, want);
    end
    addr = BASE + 32'hF;
    #1;
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL active_top: active=%b, expected 1", active);
    end
    addr = BASE - 32'h1;
    #1;
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL active_below: active=%b, expected 0", active);
    end
    addr = BASE + 32'h10;
    #1;
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL active_above: active=%b, expected 0", active);
    end
    strobe(BASE + 32'h10, 1'b1, 1'b0, 32'd0, 4'd0);
    checks++;
    if (ready !== 1'b0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL out_of_range: ready=%b rdata=%h, expected 0/0", ready, rdata);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(32'h0);
    strobe(BASE + 32'hC, 1'b0, 1'b1, 32'h0000_00FF, 4'hF);
    addr = BASE + 32'hC;
    ren  = 1'b1;
    @(posedge clk);
    #1;
    ren = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b rdata=%h, expected 0/0", ready, rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    exp_q.push_back(32'h0);
    strobe(BASE + 32'hC, 1'b1, 1'b0, 32'd0, 4'd0);
    want = exp_q.pop_front();
    checks++;
    if (ready !== 1'b1 || rdata !== want) begin
      errors++;
      $display("FAIL reset_mid_mask: ready=%b rdata=%h, expected ready=1 rdata=%h", ready, rdata, want);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    addr   = 32'd0;
    wdata  = 32'd0;
    wmask  = 4'd0;
    ren    = 1'b0;
    wen    = 1'b0;
    io     = 32'd0;
    test_reset();
    test_rise();
    test_irq();
    test_edge_wins();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
